// File: rtl/wb_sel_mux3_if.sv
// Writeback-select bus for the RV32I register-file write port.
// Carries the three candidate values, the decoder's select and the chosen result.
// The master drives the candidates and the select; the slave (the selector) returns wb_data.
interface wb_sel_mux3_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_four;
    logic [WIDTH-1:0] alu_data;
    logic [WIDTH-1:0] ld_data;
    logic [1:0]       wb_sel;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output pc_four,
        output alu_data,
        output ld_data,
        output wb_sel,
        input  wb_data
    );

    modport slave (
        input  pc_four,
        input  alu_data,
        input  ld_data,
        input  wb_sel,
        output wb_data
    );
endinterface

// File: rtl/wb_sel_mux3.sv
// Writeback-source selector for the RV32I datapath.
// Chooses PC+4, the ALU result or load data for the register-file write port.
// The reserved select 2'b11 forces all-zeros, so the write port never sees a stale or
// undefined value. REG_OUT=0 gives a pure combinational path; REG_OUT=1 adds one
// output register with a synchronous active-high reset for pipelined variants.
module wb_sel_mux3 #(
    parameter int WIDTH   = 32,
    parameter bit REG_OUT = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    wb_sel_mux3_if.slave  bus
);

    localparam logic [1:0] SEL_PC4 = 2'b00;
    localparam logic [1:0] SEL_ALU = 2'b01;
    localparam logic [1:0] SEL_LD  = 2'b10;

    // Selected candidate for the current inputs. Both build variants use it.
    logic [WIDTH-1:0] sel_s;

    // Fully specified select decode; the reserved code and any unknown select fall to zero.
    always_comb begin
        sel_s = {WIDTH{1'b0}};
        case (bus.wb_sel)
            SEL_PC4: sel_s = bus.pc_four;
            SEL_ALU: sel_s = bus.alu_data;
            SEL_LD:  sel_s = bus.ld_data;
            default: sel_s = {WIDTH{1'b0}};
        endcase
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] wb_data_r;

            // Output register: reset overrides any select, and otherwise captures the value
            // selected at this edge. This discards any value in flight when reset arrives.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wb_data_r <= {WIDTH{1'b0}};
                end else begin
                    wb_data_r <= sel_s;
                end
            end

            assign bus.wb_data = wb_data_r;
        end else begin : g_comb
            // Clock and reset have no function in the combinational build. They are folded
            // into a sink net so the ports stay in place for drop-in compatibility.
            logic unused_clk_rst_s;
            assign unused_clk_rst_s = &{1'b0, clk, rst};

            assign bus.wb_data = sel_s;
        end
    endgenerate

endmodule

// File: tb/tb_wb_sel_mux3.sv
// Directed bench for wb_sel_mux3. It builds both variants side by side:
// dut_c is combinational (REG_OUT=0) and dut_r is registered (REG_OUT=1).
module tb_wb_sel_mux3;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    wb_sel_mux3_if #(.WIDTH(32)) if_c ();
    wb_sel_mux3_if #(.WIDTH(32)) if_r ();

    wb_sel_mux3 #(.WIDTH(32), .REG_OUT(1'b0)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (if_c.slave)
    );

    wb_sel_mux3 #(.WIDTH(32), .REG_OUT(1'b1)) dut_r (
        .clk (clk),
        .rst (rst),
        .bus (if_r.slave)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] cyc_exp [4];
        logic [31:0] prev;
        n_cmp = 0;
        n_bad = 0;
        cyc_exp[0] = 32'h0000_0007;
        cyc_exp[1] = 32'hFFFF_FABD;
        cyc_exp[2] = 32'hFFFA_ABCD;
        cyc_exp[3] = 32'h0000_0000;

        rst = 1'b1;
        if_c.pc_four  = 32'd7;
        if_c.alu_data = 32'hFFFF_FABD;
        if_c.ld_data  = 32'hFFFA_ABCD;
        if_c.wb_sel   = 2'b00;
        if_r.pc_four  = 32'd7;
        if_r.alu_data = 32'hFFFF_FABD;
        if_r.ld_data  = 32'hFFFA_ABCD;
        if_r.wb_sel   = 2'b01;

        // Registered build: two reset edges give zero.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reg_reset", if_r.wb_data, 32'h0000_0000);

        // Combinational build: every select code.
        if_c.wb_sel = 2'b00; #1; check("comb_sel0", if_c.wb_data, 32'h0000_0007);
        if_c.wb_sel = 2'b01; #1; check("comb_sel1", if_c.wb_data, 32'hFFFF_FABD);
        if_c.wb_sel = 2'b10; #1; check("comb_sel2", if_c.wb_data, 32'hFFFA_ABCD);
        if_c.wb_sel = 2'b11; #1; check("comb_sel3", if_c.wb_data, 32'h0000_0000);

        // The combinational output follows a data change with no clock edge.
        if_c.wb_sel   = 2'b01;
        if_c.alu_data = 32'h1234_5678;
        #1;
        check("comb_follow", if_c.wb_data, 32'h1234_5678);

        // Data must pass bit-exact, with no extension or truncation.
        if_c.alu_data = 32'h8000_0001;
        #1;
        check("comb_bitexact", if_c.wb_data, 32'h8000_0001);
        if_c.alu_data = 32'h1234_5678;

        // Clock and reset activity has no effect on the combinational output.
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("comb_clk_rst0", if_c.wb_data, 32'h1234_5678);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("comb_clk_rst1", if_c.wb_data, 32'h1234_5678);

        // Registered build: release reset, then select load data.
        // The output changes only at the next edge.
        @(negedge clk);
        rst = 1'b0;
        if_r.wb_sel  = 2'b10;
        if_r.ld_data = 32'hFFFA_ABCD;
        #1;
        check("reg_pre_edge", if_r.wb_data, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("reg_ld_edge", if_r.wb_data, 32'hFFFA_ABCD);

        // Registered build: cycle the select through 0..3, each result one cycle late.
        prev = 32'hFFFA_ABCD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if_r.wb_sel = 2'(i);
            #1;
            check($sformatf("reg_hold%0d", i), if_r.wb_data, prev);
            @(posedge clk);
            #1;
            check($sformatf("reg_cyc%0d", i), if_r.wb_data, cyc_exp[i]);
            prev = cyc_exp[i];
        end

        // Reset mid-stream: the next edge gives zero whatever the select value.
        @(negedge clk);
        if_r.wb_sel = 2'b01;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reg_mid_rst", if_r.wb_data, 32'h0000_0000);

        // The first output after reset is the selection sampled at the first edge with rst=0.
        @(negedge clk);
        rst = 1'b0;
        if_r.wb_sel  = 2'b10;
        if_r.ld_data = 32'hA5A5_0001;
        #1;
        check("reg_post_rst_hold", if_r.wb_data, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("reg_post_rst", if_r.wb_data, 32'hA5A5_0001);

        // Registered build, reserved select: zero rather than the previous value.
        @(negedge clk);
        if_r.wb_sel = 2'b11;
        @(posedge clk);
        #1;
        check("reg_sel3", if_r.wb_data, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_sel_mux3.md
Name: wb_sel_mux3

Overview:
- Writeback-source selector for the RV32I datapath.
- Picks one of three 32-bit candidates for the register-file write port: return address (PC+4), ALU result, or load data.
- Selection is driven by the 2-bit wb_sel control from the decoder.
- Default build is purely combinational. An optional output register is provided for pipelined variants.

Parameters:
- WIDTH, 32, data width of every data port.
- REG_OUT, 0, 0 = combinational output; 1 = wb_data registered on clk (one-cycle latency).

Ports:
- clk  input  1  system clock; used only when REG_OUT=1.
- rst  input  1  synchronous, active-high reset; used only when REG_OUT=1.
- pc_four  input  WIDTH  PC+4 (link value for JAL/JALR).
- alu_data  input  WIDTH  ALU result.
- ld_data  input  WIDTH  load-unit data, already sign/zero-extended upstream.
- wb_sel  input  2  writeback source select.
- wb_data  output  WIDTH  selected writeback value.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high (rst sampled on rising clk edge).
- Select encoding:
  - 2'b00 → pc_four.
  - 2'b01 → alu_data.
  - 2'b10 → ld_data.
  - 2'b11 (reserved) → all-zeros, {WIDTH{1'b0}}. Never X, never a held value.
- REG_OUT=0:
  - wb_data is a pure function of current inputs; zero latency, no state.
  - Implement as a fully specified case/assign with a default branch; no latches.
  - clk and rst are ignored, and wb_data does not depend on them.
- REG_OUT=1:
  - On each rising clk edge, wb_data <= selection of the inputs sampled at that edge. Latency is exactly 1 cycle.
  - When rst=1 at a rising edge, wb_data <= 0. Reset wins over any select value.
  - Reset asserted mid-stream discards the in-flight value. The first post-reset output is the selection sampled at the first edge with rst=0.
  - Value holds between edges, with no glitching on input changes.
- Data is passed bit-exact: no sign extension, no arithmetic, no truncation. WIDTH applies uniformly to all data ports.
- If wb_sel is X or Z in simulation, the output is allowed to be X; synthesis treats it as a don't-care.

Test Plan:
- REG_OUT=0, pc_four=32'd7, alu_data=32'hFFFFFABD, ld_data=32'hFFFAABCD, wb_sel=0 → wb_data=32'h00000007 after settle.
- Same inputs, wb_sel=1 → wb_data=32'hFFFFFABD; wb_sel=2 → wb_data=32'hFFFAABCD.
- Same inputs, wb_sel=3 → wb_data=32'h00000000.
- REG_OUT=0:
  - Change alu_data to 32'h12345678 while wb_sel=1 → wb_data follows immediately.
  - Toggle clk/rst → no effect.
- REG_OUT=1:
  - rst=1 for 2 edges → wb_data=0.
  - Release rst, then apply wb_sel=2, ld_data=32'hFFFAABCD → wb_data=32'hFFFAABCD one edge later, unchanged before that edge.
- REG_OUT=1 with wb_sel cycling 0,1,2,3 on consecutive edges → outputs 7, FFFFFABD, FFFAABCD, 0, each one cycle late.
  - Assert rst during the sequence → next edge gives 0 regardless of wb_sel.
